// File: rtl/arb8_rr_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package arb8_rr_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Rotate left by amt: result[j] = v[(j - amt) mod 8].
    function automatic logic [N_REQ-1:0] rotl8(input logic [N_REQ-1:0] v,
                                               input logic [ID_W-1:0]  amt);
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} << amt;
        return dbl[2*N_REQ-1:N_REQ];
    endfunction

endpackage

// File: rtl/arb8_rr_prio_enc8.sv
// 8-to-3 priority encoder, bit 7 highest, with a valid flag.
// Latency: purely combinational.
// Backpressure: none.
module prio_enc8
    import arb8_rr_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [ID_W-1:0]  idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) idx = i[ID_W-1:0];
        end
        vld = |vec;
    end

endmodule

// File: rtl/arb8_rr.sv
// 8-requester arbiter, round-robin or fixed priority, with optional hold limit.
// Latency: grant registered one cycle after req is sampled; handover has no idle bubble.
// Backpressure: owner keeps the grant until done, its req drops, or the hold limit expires.
module arb8_rr
    import arb8_rr_pkg::*;
#(
    parameter bit          RR       = 1'b1,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  req,
    input  logic        done,
    output logic [7:0]  gnt,
    output logic [2:0]  gnt_id,
    output logic        gnt_vld,
    output logic        timeout
);

    localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;

    logic               owner_req;
    logic               limit_hit;
    logic               rel_now;
    logic [ID_W-1:0]    arb_ptr;
    logic [ID_W-1:0]    rot_amt;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_vld;
    logic [ID_W-1:0]    win_idx;

    // Release and re-arbitration share one encoder: on release the search
    // already uses the pointer that will be stored this edge.
    always_comb begin
        owner_req = req[gnt_id_q];
        limit_hit = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
        rel_now   = (state_q == ST_BUSY) && (done || !owner_req || limit_hit);
        arb_ptr   = ptr_q;
        if (rel_now) arb_ptr = RR ? (gnt_id_q - 3'd1) : 3'd7;
        rot_amt   = 3'd7 - arb_ptr;
        req_rot   = rotl8(req, rot_amt);
        win_idx   = enc_idx - rot_amt;
    end

    prio_enc8 u_enc (
        .vec (req_rot),
        .idx (enc_idx),
        .vld (enc_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd7;
            gnt_id_q   <= '0;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_id_q   <= gnt_id_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enc_vld) state_d = ST_BUSY;
            ST_BUSY: if (rel_now && !enc_vld) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = arb_ptr;
        gnt_id_d   = gnt_id_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = rel_now && !done && owner_req;
        if (state_q == ST_IDLE || rel_now) begin
            hold_cnt_d = '0;
            if (enc_vld) begin
                gnt_id_d = win_idx;
                gnt_d    = 8'b1 << win_idx;
            end else begin
                gnt_id_d = '0;
                gnt_d    = '0;
            end
        end else if (hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = |gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arb8_rr.sv
// Bench for arb8_rr: five parameterisations share one stimulus stream and
// each is checked every cycle against a search-loop reference model.
module tb_arb8_rr;

    localparam int NK = 5;
    localparam int unsigned HM [NK] = '{16, 4, 16, 1, 0};
    localparam bit          RRM[NK] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;

    logic [7:0] gnt_w [NK];
    logic [2:0] id_w  [NK];
    logic       vld_w [NK];
    logic       to_w  [NK];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        arb8_rr #(
            .RR       ((k == 2) ? 1'b0 : 1'b1),
            .HOLD_MAX ((k == 1) ? 4 : (k == 3) ? 1 : (k == 4) ? 0 : 16)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req),
            .done    (done),
            .gnt     (gnt_w[k]),
            .gnt_id  (id_w[k]),
            .gnt_vld (vld_w[k]),
            .timeout (to_w[k])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d t=%0t got=%0h expected=%0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: grant state per instance, search walks ptr downward.
    bit         m_busy [NK];
    logic [2:0] m_ptr  [NK];
    logic [2:0] m_id   [NK];
    int         m_cnt  [NK];
    bit         m_to   [NK];
    int         m_w;
    bit         m_rel;

    function automatic int search(input logic [2:0] p, input logic [7:0] r);
        for (int s = 0; s < 8; s++) begin
            int idx;
            idx = (int'(p) - s) & 7;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NK; k++) begin
            if (!rst_n) begin
                m_busy[k] = 1'b0; m_ptr[k] = 3'd7; m_id[k] = 3'd0; m_cnt[k] = 0; m_to[k] = 1'b0;
            end else if (!m_busy[k]) begin
                m_to[k] = 1'b0;
                m_w = search(m_ptr[k], req);
                if (m_w >= 0) begin
                    m_busy[k] = 1'b1; m_id[k] = 3'(m_w); m_cnt[k] = 0;
                end
            end else begin
                m_rel = done || !req[m_id[k]] || (HM[k] != 0 && m_cnt[k] == int'(HM[k]) - 1);
                if (m_rel) begin
                    m_to[k] = !done && req[m_id[k]];
                    if (RRM[k]) m_ptr[k] = m_id[k] - 3'd1;
                    m_w = search(m_ptr[k], req);
                    m_cnt[k] = 0;
                    if (m_w >= 0) m_id[k] = 3'(m_w);
                    else begin
                        m_busy[k] = 1'b0; m_id[k] = 3'd0;
                    end
                end else begin
                    m_to[k] = 1'b0;
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NK; k++) begin
                chk("gnt", k, 32'(gnt_w[k]), m_busy[k] ? 32'(8'b1 << m_id[k]) : 32'd0);
                chk("gnt_vld", k, 32'(vld_w[k]), 32'(m_busy[k]));
                chk("timeout", k, 32'(to_w[k]), 32'(m_to[k]));
                chk("onehot0", k, 32'($onehot0(gnt_w[k])), 32'd1);
                if (m_busy[k]) chk("gnt_id", k, 32'(id_w[k]), 32'(m_id[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid();
        req  = 8'h00;
        done = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int  sel;
        logic [7:0] rv;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #3;
        for (int k = 0; k < NK; k++) begin
            chk("rst_gnt", k, 32'(gnt_w[k]), 32'h0);
            chk("rst_id", k, 32'(id_w[k]), 32'h0);
            chk("rst_vld", k, 32'(vld_w[k]), 32'h0);
            chk("rst_to", k, 32'(to_w[k]), 32'h0);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;

        // 0x81: client 7 first, done hands over to client 0 with no bubble.
        req = 8'h81;
        tick();
        chk("d1_gnt", 0, 32'(gnt_w[0]), 32'h80);
        chk("d1_id", 0, 32'(id_w[0]), 32'd7);
        done = 1'b1;
        tick();
        chk("d1_gnt2", 0, 32'(gnt_w[0]), 32'h01);
        chk("d1_id2", 0, 32'(id_w[0]), 32'd0);
        chk("d1_vld2", 0, 32'(vld_w[0]), 32'd1);

        // All requesting, done every 2nd cycle of a grant: 7,6,...,0,7.
        reset_mid();
        req = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("rr_id", 0, 32'(id_w[0]), 32'((7 - i) & 7));
            done = 1'b0;
            tick();
            chk("rr_hold", 0, 32'(id_w[0]), 32'((7 - i) & 7));
            done = 1'b1;
            tick();
            chk("rr_vld", 0, 32'(vld_w[0]), 32'd1);
        end

        // HOLD_MAX=4 with 0x24 held: 5 for 4 cycles, 2 for 4 cycles, then 5.
        reset_mid();
        req = 8'h24;
        for (int c = 0; c < 9; c++) begin
            tick();
            chk("h4_id", 1, 32'(id_w[1]), (c < 4 || c == 8) ? 32'd5 : 32'd2);
            chk("h4_to", 1, 32'(to_w[1]), (c == 4 || c == 8) ? 32'd1 : 32'd0);
        end

        // Fixed priority with 0x0C and done every cycle: client 3 always.
        reset_mid();
        req  = 8'h0C;
        done = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("fp_gnt", 2, 32'(gnt_w[2]), 32'h08);
        end

        // HOLD_MAX=1 sole requester: regranted every cycle, timeout after the first.
        reset_mid();
        req = 8'h01;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("h1_gnt", 3, 32'(gnt_w[3]), 32'h01);
            chk("h1_to", 3, 32'(to_w[3]), (c == 0) ? 32'd0 : 32'd1);
        end

        // Owner drops its request: straight to idle, no timeout.
        reset_mid();
        req = 8'h10;
        tick();
        chk("drop_gnt0", 0, 32'(gnt_w[0]), 32'h10);
        req = 8'h00;
        tick();
        chk("drop_gnt", 0, 32'(gnt_w[0]), 32'h00);
        chk("drop_vld", 0, 32'(vld_w[0]), 32'd0);
        chk("drop_to", 0, 32'(to_w[0]), 32'd0);

        // Async reset mid-grant clears outputs at once; first grant after uses ptr=7.
        reset_mid();
        req = 8'h10;
        tick();
        chk("ar_pre", 0, 32'(gnt_w[0]), 32'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_gnt", 0, 32'(gnt_w[0]), 32'h00);
        chk("ar_vld", 0, 32'(vld_w[0]), 32'd0);
        chk("ar_to", 0, 32'(to_w[0]), 32'd0);
        req = 8'h03;
        #1 rst_n = 1'b1;
        tick();
        chk("ar_first", 0, 32'(gnt_w[0]), 32'h02);
        chk("ar_first_id", 0, 32'(id_w[0]), 32'd1);

        // Randomised traffic, occasional async reset.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if ($urandom_range(99) < 30) begin
                sel = $urandom_range(3);
                rv  = 8'($urandom);
                case (sel)
                    0: req = 8'h00;
                    1: req = 8'b1 << $urandom_range(7);
                    2: req = rv & 8'($urandom);
                    default: req = rv;
                endcase
            end
            done = ($urandom_range(3) == 0);
            if ($urandom_range(499) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb8_rr.md
Name: arb8_rr

Overview:
- 8-requester arbiter that shares one resource among eight clients.
- Uses an 8-to-3 priority encoder (bit 7 highest) on a rotated request vector to pick a winner.
- Holds the grant until the owner releases it or a hold limit expires.
- Sits in front of any shared datapath port; fixed-priority or round-robin selectable.

Parameters:
- RR, 1, 1 = round-robin pointer rotation; 0 = fixed priority (bit 7 highest, pointer frozen at 7).
- HOLD_MAX, 16, maximum cycles one grant may be held; 0 disables the limit. Legal range 0..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector, bit i = client i; level-sensitive.
- done  input  1  current owner releases the grant this cycle.
- gnt  output  8  one-hot grant, registered; all zero when idle.
- gnt_id  output  3  binary index of the grantee; valid only when gnt_vld=1.
- gnt_vld  output  1  a grant is active (OR of gnt).
- timeout  output  1  one-cycle pulse: the grant was revoked by the hold limit.

Behaviour:
- Reset (rst_n=0, async):
  - gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - State=IDLE, ptr=7, hold_cnt=0.
- States:
  - IDLE: no grant.
  - BUSY: grant held.
- Search order: ptr, ptr-1, …, 0, 7, …, ptr+1 (mod 8).
  - Implemented by rotating req left by (7-ptr), priority-encoding, and adding the offset back mod 8.
- IDLE:
  - If req≠0, the winner is registered on the next edge: gnt/gnt_id/gnt_vld update one cycle after req is sampled. State→BUSY, hold_cnt=0.
  - If req=0, stay in IDLE with outputs zero.
- BUSY release condition, in any cycle where at least one holds:
  - done=1.
  - req[gnt_id]=0.
  - HOLD_MAX≠0 and hold_cnt==HOLD_MAX-1.
  - Otherwise hold_cnt increments and gnt is unchanged.
- On release:
  - If RR=1, ptr←gnt_id-1 (mod 8), so the previous owner becomes lowest priority.
  - Re-arbitration happens in the same cycle using the new ptr and current req, with the old owner masked only if its req=0.
    - Any winner: registered next edge with no bubble. State stays BUSY, hold_cnt=0.
    - No winner: gnt=0, State→IDLE.
  - The previous owner is granted again only if it is the sole requester.
- timeout:
  - Asserted on the edge following a release caused only by the hold limit (done=0, req[gnt_id]=1).
  - Asserted for exactly one cycle, even if the same client is re-granted.
- Simultaneous events:
  - done and timeout in the same cycle: treated as done, timeout=0.
  - New requests arriving while BUSY never preempt the current owner.
- Fixed-priority mode (RR=0): ptr stays 7, so the highest index always wins.
- HOLD_MAX=1: every grant lasts exactly one cycle. A sole requester holding req is regranted every cycle with timeout pulsing each cycle.
- Reset mid-grant: outputs clear immediately (async). The first grant after reset uses ptr=7.
- Width rules:
  - hold_cnt is 8 bits and saturates unused when HOLD_MAX=0.
  - ptr and gnt_id are 3 bits; arithmetic wraps mod 8.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_vld == |gnt.
  - gnt_id matches gnt.

Decomposition:
- Shared package/header:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1.
  - constant N_REQ=8.
  - ID_W=3.
- One sub-module: prio_enc8, a combinational 8-to-3 priority encoder (bit 7 highest) with a valid output, used on the rotated vector.
- Rotation, pointer, counter and FSM live in arb8_rr.

Test Plan:
- Reset, then req=8'h81 with RR=1 → grant registered one cycle later: gnt=8'h80, gnt_id=7. On done: gnt=8'h01, gnt_id=0 next cycle, no idle bubble.
- req=8'hFF constant, done pulsed every 2nd cycle of a grant → grant order 7,6,5,4,3,2,1,0,7. Each gnt_vld stays continuous.
- HOLD_MAX=4, req=8'h24 held, done=0 → client 5 holds 4 cycles, timeout pulses 1 cycle, then client 2 is granted. Client 2 times out after 4 cycles, then client 5 again.
- RR=0, req=8'h0C, done every cycle → gnt stays 8'h08 (client 3) each re-arbitration; client 2 is never served while client 3 requests.
- Owner drops req (req 8'h10 → 8'h00) mid-grant → gnt=0 and gnt_vld=0 next cycle, state IDLE, timeout=0.
- rst_n asserted low mid-grant, asynchronously between edges → gnt, gnt_vld and timeout go 0 immediately. After release with req=8'h03, the first grant goes to client 1 (ptr=7).
